// File: rtl/mips_mmio_bridge_pkg.sv
// Shared definitions for the MIPS memory-mapped I/O bridge: register offsets,
// CTRL bit layout, CPU request payload and debounce state encoding.
package mips_mmio_bridge_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CMP_W  = 16;

    localparam logic [1:0] OFF_SW    = 2'd0;
    localparam logic [1:0] OFF_LED   = 2'd1;
    localparam logic [1:0] OFF_TIMER = 2'd2;
    localparam logic [1:0] OFF_CTRL  = 2'd3;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_IRQ     = 1;
    localparam int unsigned CTRL_CMP_LSB = 16;

    typedef struct packed {
        logic              cs;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cpu_req_t;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_SETTLING = 1'b1
    } db_state_e;

    // CTRL read-back image; unused bits read as zero
    function automatic logic [DATA_W-1:0] ctrl_word(input logic en, input logic irq,
                                                    input logic [CMP_W-1:0] cmp);
        return {cmp, 14'b0, irq, en};
    endfunction

endpackage

// File: rtl/mips_mmio_bridge_debounce.sv
// Switch debouncer: 2-flop synchroniser followed by a whole-vector settle FSM.
module mmio_debounce
    import mips_mmio_bridge_pkg::*;
#(
    parameter int unsigned SW_W     = 8,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [SW_W-1:0] sw_in,
    output logic [SW_W-1:0] sw_db
);

    localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [SW_W-1:0]  sync1, sync2;
    logic [SW_W-1:0]  cand, cand_nxt;
    logic [SW_W-1:0]  db_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    db_state_e        state, state_nxt;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            cnt   <= '0;
            sw_db <= '0;
            state <= DB_STABLE;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
            sw_db <= db_nxt;
            state <= state_nxt;
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            DB_STABLE:   if (sync2 != cand) state_nxt = DB_SETTLING;
            DB_SETTLING: if (sync2 == cand && cnt == CNT_LAST) state_nxt = DB_STABLE;
            default:     state_nxt = DB_STABLE;
        endcase
    end

    // Candidate tracking, settle counter and debounced output
    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        db_nxt   = sw_db;
        case (state)
            DB_STABLE: begin
                if (sync2 != cand) begin
                    cand_nxt = sync2;
                    cnt_nxt  = '0;
                end
            end
            DB_SETTLING: begin
                if (sync2 != cand) begin
                    cand_nxt = sync2;
                    cnt_nxt  = '0;
                end else if (cnt == CNT_LAST) begin
                    db_nxt = cand;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mmio_bridge.sv
// Bridge between the MIPS core memory port and word RAM; the top four word
// addresses hold switch, LED, timer and control registers.
module mips_mmio_bridge
    import mips_mmio_bridge_pkg::*;
#(
    parameter logic [ADDR_W-1:0] IO_BASE  = 7'h7C,
    parameter int unsigned       PRESCALE = 4,
    parameter int unsigned       DEBOUNCE = 3,
    parameter int unsigned       SW_W     = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [SW_W-1:0]   sw_in,
    output logic [SW_W-1:0]   led_out,
    output logic              timer_irq
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    cpu_req_t          req;
    logic              io_sel, io_wr;
    logic              wr_led, wr_timer, wr_ctrl;
    logic [SW_W-1:0]   sw_db;
    logic [SW_W-1:0]   led_nxt;
    logic [DATA_W-1:0] count, count_nxt;
    logic [PS_W-1:0]   presc, presc_nxt;
    logic              ctrl_en, en_nxt, ctrl_irq, irq_nxt;
    logic [CMP_W-1:0]  ctrl_cmp, cmp_nxt;
    logic              en_run, tick, irq_set;
    logic [DATA_W-1:0] rd_mux, io_rdata;
    logic              sel_q;

    assign req = '{cs: cpu_cs, we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};

    // Address decode and RAM pass-through
    assign io_sel    = req.cs && (req.addr[ADDR_W-1:2] == IO_BASE[ADDR_W-1:2]);
    assign ram_cs    = req.cs & ~io_sel;
    assign ram_we    = req.we & ~io_sel;
    assign ram_addr  = req.addr;
    assign ram_wdata = req.wdata;

    assign io_wr    = req.cs & req.we & io_sel;
    assign wr_led   = io_wr && (req.addr[1:0] == OFF_LED);
    assign wr_timer = io_wr && (req.addr[1:0] == OFF_TIMER);
    assign wr_ctrl  = io_wr && (req.addr[1:0] == OFF_CTRL);

    // Writing EN=0 stops the prescaler in the same cycle as the write
    assign en_run = ctrl_en & ~(wr_ctrl & ~req.wdata[CTRL_EN]);

    mmio_debounce #(
        .SW_W     (SW_W),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .CLK   (CLK),
        .RST   (RST),
        .sw_in (sw_in),
        .sw_db (sw_db)
    );

    // Timer, control and LED next-state; CPU writes beat ticks, IRQ set beats W1C
    always_comb begin
        presc_nxt = presc;
        tick      = 1'b0;
        if (en_run) begin
            if (presc == PS_LAST) begin
                presc_nxt = '0;
                tick      = 1'b1;
            end else begin
                presc_nxt = presc + PS_W'(1);
            end
        end

        count_nxt = count;
        irq_set   = 1'b0;
        if (wr_timer) begin
            count_nxt = req.wdata;
        end else if (tick) begin
            if (count == DATA_W'(ctrl_cmp)) begin
                count_nxt = '0;
                irq_set   = 1'b1;
            end else begin
                count_nxt = count + DATA_W'(1);
            end
        end

        en_nxt  = ctrl_en;
        cmp_nxt = ctrl_cmp;
        irq_nxt = ctrl_irq;
        if (wr_ctrl) begin
            en_nxt  = req.wdata[CTRL_EN];
            cmp_nxt = req.wdata[CTRL_CMP_LSB +: CMP_W];
            irq_nxt = ctrl_irq & ~req.wdata[CTRL_IRQ];
        end
        if (irq_set) irq_nxt = 1'b1;

        led_nxt = wr_led ? req.wdata[SW_W-1:0] : led_out;
    end

    // Register file
    always_ff @(posedge CLK) begin
        if (RST) begin
            led_out  <= '0;
            count    <= '0;
            presc    <= '0;
            ctrl_en  <= 1'b0;
            ctrl_irq <= 1'b0;
            ctrl_cmp <= '0;
        end else begin
            led_out  <= led_nxt;
            count    <= count_nxt;
            presc    <= presc_nxt;
            ctrl_en  <= en_nxt;
            ctrl_irq <= irq_nxt;
            ctrl_cmp <= cmp_nxt;
        end
    end

    assign timer_irq = ctrl_irq;

    always_comb begin
        rd_mux = '0;
        case (req.addr[1:0])
            OFF_SW:    rd_mux = DATA_W'(sw_db);
            OFF_LED:   rd_mux = DATA_W'(led_out);
            OFF_TIMER: rd_mux = count;
            OFF_CTRL:  rd_mux = ctrl_word(ctrl_en, ctrl_irq, ctrl_cmp);
            default:   rd_mux = '0;
        endcase
    end

    // I/O read path sampled on the falling edge, aligned with RAM read latency
    always_ff @(negedge CLK) begin
        if (RST) begin
            io_rdata <= '0;
            sel_q    <= 1'b0;
        end else begin
            io_rdata <= rd_mux;
            sel_q    <= io_sel;
        end
    end

    assign cpu_rdata = sel_q ? io_rdata : ram_rdata;

endmodule

// File: tb/tb_mips_mmio_bridge.sv
// Self-checking bench for mips_mmio_bridge: directed table, corner sequences
// and randomized traffic against a register-level reference model.
module tb_mips_mmio_bridge;

    localparam int unsigned P = 4;
    localparam int unsigned D = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cpu_cs, cpu_we;
    logic [6:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        ram_cs, ram_we;
    logic [6:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [7:0]  sw_in, led_out;
    logic        timer_irq;

    mips_mmio_bridge dut (
        .CLK(CLK), .RST(RST),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .sw_in(sw_in), .led_out(led_out), .timer_irq(timer_irq)
    );

    always #5 CLK = ~CLK;

    // Word RAM stand-in, updated on the falling edge
    logic [31:0] mem [128] = '{default: '0};
    always @(negedge CLK) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_cs) ram_rdata <= mem[ram_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  m_led, m_swdb, m_s1, m_s2, m_seen;
    logic [31:0] m_count;
    logic        m_en, m_irq;
    logic [15:0] m_cmp;
    int          m_presc, m_run;
    logic [31:0] exp_mem [128] = '{default: '0};
    logic [31:0] last_rd;
    logic [7:0]  cur_sw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: condition not reached within cycle budget", name);
    endtask

    task automatic m_reset();
        m_led = '0; m_swdb = '0; m_s1 = '0; m_s2 = '0; m_seen = '0;
        m_count = '0; m_en = 1'b0; m_irq = 1'b0; m_cmp = '0; m_presc = 0;
        m_run = D + 1;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] off);
        case (off)
            2'd0:    return {24'b0, m_swdb};
            2'd1:    return {24'b0, m_led};
            2'd2:    return m_count;
            default: return {m_cmp, 14'b0, m_irq, m_en};
        endcase
    endfunction

    task automatic m_update(input logic rst, input logic cs, input logic we,
                            input logic [6:0] addr, input logic [31:0] wd, input logic [7:0] sw);
        logic io, wr, tick, set;
        if (rst) begin
            m_reset();
            return;
        end
        io = cs && (addr[6:2] == 5'h1F);
        wr = io && we;
        // switches: value accepted after D+1 consecutive identical synchronised samples
        if (m_s2 == m_seen) begin
            if (m_run < D + 1) m_run++;
        end else begin
            m_run = 1;
        end
        m_seen = m_s2;
        if (m_run >= D + 1) m_swdb = m_s2;
        m_s2 = m_s1;
        m_s1 = sw;
        tick = 1'b0;
        if (m_en && !(wr && addr[1:0] == 2'd3 && !wd[0])) begin
            if (m_presc == P - 1) begin m_presc = 0; tick = 1'b1; end
            else m_presc++;
        end
        set = 1'b0;
        if (wr && addr[1:0] == 2'd2) m_count = wd;
        else if (tick) begin
            if (m_count == {16'b0, m_cmp}) begin m_count = '0; set = 1'b1; end
            else m_count = m_count + 32'd1;
        end
        if (wr && addr[1:0] == 2'd3) begin
            m_irq = m_irq && !wd[1];
            m_en  = wd[0];
            m_cmp = wd[31:16];
        end
        if (set) m_irq = 1'b1;
        if (wr && addr[1:0] == 2'd1) m_led = wd[7:0];
    endtask

    // One bus cycle: entered and left 1 time unit after a rising edge
    task automatic step(input logic rst, input logic cs, input logic we,
                        input logic [6:0] addr, input logic [31:0] wd, input logic [7:0] sw);
        logic io;
        logic [31:0] exp_rd;
        RST = rst; cpu_cs = cs; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; sw_in = sw;
        #1;
        io = cs && (addr[6:2] == 5'h1F);
        chk("ram_cs", 32'(ram_cs), 32'(cs && !io));
        chk("ram_we", 32'(ram_we), 32'(we && !io));
        chk("ram_addr", 32'(ram_addr), 32'(addr));
        chk("ram_wdata", ram_wdata, wd);
        exp_rd = io ? m_read(addr[1:0]) : exp_mem[addr];
        @(negedge CLK);
        #1;
        if (cs && we && !io) exp_mem[addr] = wd;
        last_rd = cpu_rdata;
        if (!rst && cs && !we) chk("cpu_rdata", cpu_rdata, exp_rd);
        @(posedge CLK);
        m_update(rst, cs, we, addr, wd, sw);
        #1;
        chk("led_out", 32'(led_out), 32'(m_led));
        chk("timer_irq", 32'(timer_irq), 32'(m_irq));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, cur_sw);
    endtask

    task automatic rd(input logic [6:0] a);
        step(1'b0, 1'b1, 1'b0, a, 32'd0, cur_sw);
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, a, d, cur_sw);
    endtask

    typedef struct {
        logic        cs, we;
        logic [6:0]  addr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int guard;
        tbl[0]  = '{1'b1, 1'b1, 7'h05, 32'hDEADBEEF, 1'b0, 32'h0,        8'h00};
        tbl[1]  = '{1'b1, 1'b0, 7'h05, 32'h0,        1'b1, 32'hDEADBEEF, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 7'h7D, 32'h000000A5, 1'b0, 32'h0,        8'hA5};
        tbl[3]  = '{1'b1, 1'b0, 7'h7D, 32'h0,        1'b1, 32'h000000A5, 8'hA5};
        tbl[4]  = '{1'b1, 1'b0, 7'h7C, 32'h0,        1'b1, 32'h0,        8'hA5};
        tbl[5]  = '{1'b1, 1'b1, 7'h7C, 32'hFFFFFFFF, 1'b0, 32'h0,        8'hA5};
        tbl[6]  = '{1'b1, 1'b0, 7'h7C, 32'h0,        1'b1, 32'h0,        8'hA5};
        tbl[7]  = '{1'b1, 1'b0, 7'h7F, 32'h0,        1'b1, 32'h0,        8'hA5};
        tbl[8]  = '{1'b1, 1'b1, 7'h7D, 32'h12345600, 1'b0, 32'h0,        8'h00};
        tbl[9]  = '{1'b1, 1'b0, 7'h7D, 32'h0,        1'b1, 32'h0,        8'h00};
        tbl[10] = '{1'b1, 1'b1, 7'h7B, 32'h0BADF00D, 1'b0, 32'h0,        8'h00};
        tbl[11] = '{1'b1, 1'b0, 7'h7B, 32'h0,        1'b1, 32'h0BADF00D, 8'h00};
        tbl[12] = '{1'b1, 1'b1, 7'h7D, 32'h000000A5, 1'b0, 32'h0,        8'hA5};
        tbl[13] = '{1'b1, 1'b0, 7'h7E, 32'h0,        1'b1, 32'h0,        8'hA5};

        m_reset();
        cur_sw = 8'h00;
        step(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, cur_sw);
        step(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, cur_sw);
        chk("reset_led", 32'(led_out), 32'h0);
        chk("reset_irq", 32'(timer_irq), 32'h0);

        for (int i = 0; i < 14; i++) begin
            step(1'b0, tbl[i].cs, tbl[i].we, tbl[i].addr, tbl[i].wd, cur_sw);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), last_rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_led", i), 32'(led_out), 32'(tbl[i].exp_led));
        end

        // Debounce: ten toggling cycles, then hold 8'h3C
        for (int i = 0; i < 10; i++) begin
            cur_sw = (i % 2 == 0) ? 8'h3C : 8'h00;
            rd(7'h7C);
        end
        cur_sw = 8'h3C;
        for (int k = 10; k <= 16; k++) begin
            rd(7'h7C);
            chk($sformatf("db_k%0d", k), last_rd, (k < 16) ? 32'h0 : 32'h3C);
        end

        // Timer: CMP=3, EN=1 -> wraps on the fourth tick (16 cycles after enable)
        wr(7'h7F, 32'h0003_0001);
        repeat (15) idle();
        chk("tmr_irq_pre", 32'(timer_irq), 32'h0);
        rd(7'h7E);
        chk("tmr_cnt3", last_rd, 32'd3);
        chk("tmr_irq_wrap", 32'(timer_irq), 32'h1);
        rd(7'h7E);
        chk("tmr_cnt0", last_rd, 32'd0);

        // W1C coinciding with a compare match: set wins
        wr(7'h7F, 32'h0003_0003);
        chk("w1c_clear", 32'(timer_irq), 32'h0);
        guard = 0;
        while (!(m_en && m_presc == P - 1 && m_count == {16'b0, m_cmp}) && guard < 64) begin
            idle(); guard++;
        end
        if (guard >= 64) timeout("w1c_match_wait");
        wr(7'h7F, 32'h0003_0003);
        chk("w1c_vs_match", 32'(timer_irq), 32'h1);

        // TIMER write on a tick cycle: write wins
        guard = 0;
        while (!(m_en && m_presc == P - 1) && guard < 16) begin idle(); guard++; end
        if (guard >= 16) timeout("tick_wait");
        wr(7'h7E, 32'd100);
        rd(7'h7E);
        chk("wr_vs_tick", last_rd, 32'd100);

        // 32-bit wrap without flag
        wr(7'h7F, 32'h0003_0003);
        wr(7'h7E, 32'hFFFF_FFFF);
        guard = 0;
        while (m_count == 32'hFFFF_FFFF && guard < 16) begin idle(); guard++; end
        if (guard >= 16) timeout("wrap_wait");
        rd(7'h7E);
        chk("cnt_wrap", last_rd, 32'd0);
        chk("wrap_noirq", 32'(timer_irq), 32'h0);

        // Disable on a would-be tick cycle: prescaler freezes at once
        guard = 0;
        while (!(m_en && m_presc == P - 1) && guard < 16) begin idle(); guard++; end
        if (guard >= 16) timeout("freeze_wait");
        wr(7'h7F, 32'h0003_0000);
        repeat (6) idle();
        rd(7'h7E);

        // Reset mid-run with timer running, LEDs lit and debouncer settling
        wr(7'h7F, 32'h0003_0001);
        wr(7'h7D, 32'h0000_00FF);
        chk("led_ff", 32'(led_out), 32'hFF);
        cur_sw = 8'h0F;
        repeat (3) idle();
        step(1'b1, 1'b1, 1'b1, 7'h7D, 32'h0000_0011, cur_sw);
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        rd(7'h7E);
        chk("rst_cnt", last_rd, 32'h0);
        rd(7'h7C);
        chk("rst_sw", last_rd, 32'h0);
        rd(7'h7F);
        chk("rst_ctrl", last_rd, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic        r_rst, r_cs, r_we;
            logic [6:0]  r_addr;
            logic [31:0] r_wd;
            r_rst = ($urandom_range(0, 99) == 0);
            r_cs  = !r_rst && ($urandom_range(0, 3) != 0);
            r_we  = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 1) == 1) ? {5'h1F, 2'($urandom)} : 7'($urandom);
            r_wd  = $urandom;
            if (r_addr[6:2] == 5'h1F && r_addr[1:0] == 2'd3)
                r_wd = {16'($urandom_range(0, 4)), 14'($urandom), 2'($urandom)};
            else if (r_addr[6:2] == 5'h1F && r_addr[1:0] == 2'd2 && $urandom_range(0, 1) == 1)
                r_wd = 32'($urandom_range(0, 6));
            if ($urandom_range(0, 5) == 0) cur_sw = 8'($urandom);
            step(r_rst, r_cs, r_we, r_addr, r_wd, cur_sw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
